// File: rtl/e203_exu_flush_sched_pkg.sv
// Shared types for the EXU flush/halt scheduler.
// State encodings and index-width helper.
package e203_exu_flush_sched_pkg;

   localparam int FLUSH_REQ_NUM = 2;
   localparam int FLUSH_PC_SIZE = 32;

   typedef enum logic [1:0] {
      FSCH_IDLE  = 2'd0,
      FSCH_FLUSH = 2'd1,
      FSCH_HALT  = 2'd2
   } fsch_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/e203_exu_flush_prio.sv
// Fixed-priority picker: lowest set request wins.
// Produces a one-hot grant and its binary index.
module e203_exu_flush_prio
   import e203_exu_flush_sched_pkg::*;
#(
   parameter int NREQ = FLUSH_REQ_NUM,
   parameter int IW   = idx_w(FLUSH_REQ_NUM)
) (
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (req[i] && !any) begin
            gnt[i] = 1'b1;
            idx    = IW'(i);
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/e203_exu_flush_sched.sv
// Arbitrates the IFU flush port between flush requesters
// and the WFI halt request; flush wins over halt.
module e203_exu_flush_sched
   import e203_exu_flush_sched_pkg::*;
#(
   parameter int NREQ    = FLUSH_REQ_NUM,
   parameter int PC_SIZE = FLUSH_PC_SIZE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         src_req,
   output logic [NREQ-1:0]         src_ack,
   input  logic [NREQ*PC_SIZE-1:0] src_op1,
   input  logic [NREQ*PC_SIZE-1:0] src_op2,
   input  logic [NREQ*PC_SIZE-1:0] src_pc,
   output logic                    pipe_flush_req,
   input  logic                    pipe_flush_ack,
   output logic [PC_SIZE-1:0]      pipe_flush_add_op1,
   output logic [PC_SIZE-1:0]      pipe_flush_add_op2,
   output logic [PC_SIZE-1:0]      pipe_flush_pc,
   output logic                    flush_pulse,
   input  logic                    halt_req,
   output logic                    halt_ifu_req,
   input  logic                    halt_ifu_ack,
   output logic                    halt_active
);

   localparam int IW = idx_w(NREQ);

   fsch_state_e     state_q, state_d;
   logic [IW-1:0]   gnt_idx_q, gnt_idx_d;
   logic [NREQ-1:0] pick_oh;
   logic [NREQ-1:0] lock_oh;
   logic [NREQ-1:0] sel_oh;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;

   e203_exu_flush_prio #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_prio (
      .req (src_req),
      .gnt (pick_oh),
      .idx (pick_idx),
      .any (pick_any)
   );

   always_comb begin
      lock_oh = '0;
      for (int i = 0; i < NREQ; i++) begin
         lock_oh[i] = (gnt_idx_q == IW'(i));
      end
   end

   always_comb begin
      state_d        = state_q;
      gnt_idx_d      = gnt_idx_q;
      pipe_flush_req = 1'b0;
      src_ack        = '0;
      sel_oh         = '0;
      unique case (state_q)
         FSCH_IDLE: begin
            if (pick_any) begin
               pipe_flush_req = 1'b1;
               sel_oh         = pick_oh;
               if (pipe_flush_ack) begin
                  src_ack = pick_oh;
               end else begin
                  gnt_idx_d = pick_idx;
                  state_d   = FSCH_FLUSH;
               end
            end else if (halt_req) begin
               state_d = FSCH_HALT;
            end
         end
         // Grant stays locked until ack, even against idx 0
         FSCH_FLUSH: begin
            pipe_flush_req = 1'b1;
            sel_oh         = lock_oh;
            if (pipe_flush_ack) begin
               src_ack = lock_oh;
               state_d = FSCH_IDLE;
            end
         end
         FSCH_HALT: begin
            if (!halt_req || src_req[0]) begin
               state_d = FSCH_IDLE;
            end
         end
         default: begin
            state_d = FSCH_IDLE;
         end
      endcase
   end

   always_comb begin
      pipe_flush_add_op1 = '0;
      pipe_flush_add_op2 = '0;
      pipe_flush_pc      = '0;
      for (int i = 0; i < NREQ; i++) begin
         pipe_flush_add_op1 |= src_op1[i*PC_SIZE +: PC_SIZE]
                             & {PC_SIZE{sel_oh[i]}};
         pipe_flush_add_op2 |= src_op2[i*PC_SIZE +: PC_SIZE]
                             & {PC_SIZE{sel_oh[i]}};
         pipe_flush_pc      |= src_pc[i*PC_SIZE +: PC_SIZE]
                             & {PC_SIZE{sel_oh[i]}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FSCH_IDLE;
         gnt_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_idx_q <= gnt_idx_d;
      end
   end

   assign halt_ifu_req = (state_q == FSCH_HALT);
   assign flush_pulse  = pipe_flush_req & pipe_flush_ack;
   assign halt_active  = halt_ifu_req & halt_ifu_ack;

   a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == FSCH_FLUSH) |-> src_req[gnt_idx_q]);

   a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0({halt_ifu_req, pipe_flush_req}));

endmodule

// File: tb/tb_e203_exu_flush_sched.sv
// Random + directed bench for e203_exu_flush_sched
// against a cycle-level behavioural model.
module tb_e203_exu_flush_sched;

   localparam int N = 2;
   localparam int W = 32;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   src_req;
   logic [N-1:0]   src_ack;
   logic [N*W-1:0] src_op1, src_op2, src_pc;
   logic           pipe_flush_req, pipe_flush_ack;
   logic [W-1:0]   op1_o, op2_o, pc_o;
   logic           flush_pulse;
   logic           halt_req, halt_ifu_req, halt_ifu_ack, halt_active;

   int n_chk  = 0;
   int n_fail = 0;

   int         m_lock = -1;
   bit         m_halt = 1'b0;
   logic [1:0] e_ack;
   logic [1:0] o_ack;
   logic       o_pfr, o_hir;

   always #5 clk = ~clk;

   e203_exu_flush_sched #(.NREQ(N), .PC_SIZE(W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .src_req            (src_req),
      .src_ack            (src_ack),
      .src_op1            (src_op1),
      .src_op2            (src_op2),
      .src_pc             (src_pc),
      .pipe_flush_req     (pipe_flush_req),
      .pipe_flush_ack     (pipe_flush_ack),
      .pipe_flush_add_op1 (op1_o),
      .pipe_flush_add_op2 (op2_o),
      .pipe_flush_pc      (pc_o),
      .flush_pulse        (flush_pulse),
      .halt_req           (halt_req),
      .halt_ifu_req       (halt_ifu_req),
      .halt_ifu_ack       (halt_ifu_ack),
      .halt_active        (halt_active)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive, compare against model, advance model at posedge
   task automatic step(input logic [1:0] req, input logic ack,
                       input logic hr, input logic ha);
      int         g;
      logic       ef, eh;
      logic [1:0] ea;
      logic [1:0] one;
      int         nlock;
      bit         nhalt;
      @(negedge clk);
      src_req        = req;
      pipe_flush_ack = ack;
      halt_req       = hr;
      halt_ifu_ack   = ha;
      #1;
      one   = 2'b01;
      g     = -1;
      ef    = 1'b0;
      eh    = 1'b0;
      ea    = 2'b00;
      nlock = m_lock;
      nhalt = m_halt;
      if (m_halt) begin
         eh    = 1'b1;
         nhalt = hr && !req[0];
      end else if (m_lock >= 0) begin
         ef = 1'b1;
         g  = m_lock;
         if (ack) begin
            ea    = one << g;
            nlock = -1;
         end
      end else if (req != 0) begin
         ef = 1'b1;
         for (int i = N - 1; i >= 0; i--) if (req[i]) g = i;
         if (ack) ea = one << g;
         else nlock = g;
      end else if (hr) begin
         nhalt = 1'b1;
      end
      check("pipe_flush_req", 64'(pipe_flush_req), 64'(ef));
      check("halt_ifu_req", 64'(halt_ifu_req), 64'(eh));
      check("src_ack", 64'(src_ack), 64'(ea));
      check("flush_pulse", 64'(flush_pulse), 64'(ef & ack));
      check("halt_active", 64'(halt_active), 64'(eh & ha));
      check("onehot0", 64'(halt_ifu_req & pipe_flush_req), 64'(0));
      if (ef) begin
         check("op1", 64'(op1_o), 64'(src_op1[g*W +: W]));
         check("op2", 64'(op2_o), 64'(src_op2[g*W +: W]));
         check("pc", 64'(pc_o), 64'(src_pc[g*W +: W]));
      end
      e_ack = ea;
      o_ack = src_ack;
      o_pfr = pipe_flush_req;
      o_hir = halt_ifu_req;
      @(posedge clk);
      m_lock = nlock;
      m_halt = nhalt;
   endtask

   task automatic async_reset(input string tag);
      @(negedge clk);
      src_req        = '0;
      pipe_flush_ack = 1'b0;
      halt_req       = 1'b0;
      halt_ifu_ack   = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_pfr"}, 64'(pipe_flush_req), 64'(0));
      check({tag, "_hir"}, 64'(halt_ifu_req), 64'(0));
      check({tag, "_ack"}, 64'(src_ack), 64'(0));
      m_lock = -1;
      m_halt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] pend;
      logic       hr;
      rst_n          = 1'b0;
      src_req        = '0;
      pipe_flush_ack = 1'b0;
      halt_req       = 1'b0;
      halt_ifu_ack   = 1'b0;
      src_op1 = {32'h1000_0011, 32'h1000_0010};
      src_op2 = {32'h2000_0021, 32'h2000_0020};
      src_pc  = {32'h3000_0031, 32'h3000_0030};
      repeat (2) @(negedge clk);
      check("rst_pfr", 64'(pipe_flush_req), 64'(0));
      check("rst_hir", 64'(halt_ifu_req), 64'(0));
      check("rst_ack", 64'(src_ack), 64'(0));
      check("rst_pulse", 64'(flush_pulse), 64'(0));
      rst_n = 1'b1;

      // Zero-latency flush with immediate ack
      step(2'b10, 1'b1, 1'b0, 1'b0);
      check("t1_ack", 64'(o_ack), 64'(2'b10));

      // idx0 wins, held 3 cycles, then idx1
      step(2'b11, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      check("t2_ack0", 64'(o_ack), 64'(2'b01));
      step(2'b10, 1'b1, 1'b0, 1'b0);
      check("t2_ack1", 64'(o_ack), 64'(2'b10));

      // No preemption of a locked idx1
      step(2'b10, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      check("t3_ack1", 64'(o_ack), 64'(2'b10));
      step(2'b01, 1'b1, 1'b0, 1'b0);
      check("t3_ack0", 64'(o_ack), 64'(2'b01));

      // Halt entry and exit
      step(2'b00, 1'b0, 1'b1, 1'b0);
      check("t4_idle", 64'(o_hir), 64'(0));
      step(2'b00, 1'b0, 1'b1, 1'b1);
      check("t4_hir", 64'(o_hir), 64'(1));
      step(2'b00, 1'b0, 1'b0, 1'b1);
      step(2'b00, 1'b0, 1'b0, 1'b0);
      check("t4_exit", 64'(o_hir), 64'(0));

      // Halt: idx1 stays pending, idx0 wakes
      step(2'b00, 1'b0, 1'b1, 1'b0);
      step(2'b10, 1'b0, 1'b1, 1'b0);
      step(2'b10, 1'b0, 1'b1, 1'b0);
      check("t5_keep", 64'(o_hir), 64'(1));
      step(2'b11, 1'b0, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      check("t5_wake_hir", 64'(o_hir), 64'(0));
      check("t5_wake_pfr", 64'(o_pfr), 64'(1));
      step(2'b10, 1'b1, 1'b1, 1'b0);

      // Async reset mid-FLUSH and mid-HALT
      step(2'b01, 1'b0, 1'b0, 1'b0);
      async_reset("rst_flush");
      step(2'b00, 1'b0, 1'b1, 1'b0);
      step(2'b00, 1'b0, 1'b1, 1'b1);
      async_reset("rst_halt");

      // Random run; requesters hold until acked, ops frozen while pending
      pend = '0;
      hr   = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         pend &= ~e_ack;
         for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
               src_op1[i*W +: W] = $urandom;
               src_op2[i*W +: W] = $urandom;
               src_pc[i*W +: W]  = $urandom;
               if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
            end
         end
         if ($urandom_range(0, 5) == 0) hr = ~hr;
         step(pend, $urandom_range(0, 2) == 0, hr, 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
